cache_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer in front of cache_top; shares the single cache access port between NUM_REQ requesters (e.g. instruction and data trace streams).
- Accepts one request per arbitration slot via valid/ready.
- Drives cache_addr/cache_op/cache_lvl stable for HOLD_CYCLES clocks per access (cache_top samples a held request), then returns cache_op to idle.
- Filters illegal opcodes and counts issued accesses.

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_req_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/cache_req_arbiter.sv | 120 ++++++++++++
 tb/tb_cache_req_arbiter.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared opcodes, default widths and state type for the cache request arbiter.
package cache_pkg;

  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_IDLE  = 8'h00;

  localparam int DEF_ADDR_W = 48;
  localparam int DEF_CNT_W  = 12;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/cache_req_arbiter_if.sv
// Requester-side bundle and cache-port bundle of the arbiter; the arbiter is the slave.
interface cache_req_arbiter_if
  import cache_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*8-1:0]      req_op;
  logic [NUM_REQ-1:0]        req_lvl;
  logic [NUM_REQ-1:0]        req_ready;

  logic [ADDR_W-1:0]         cache_addr;
  logic [7:0]                cache_op;
  logic                      cache_lvl;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic                      bad_op;
  logic [CNT_W-1:0]          issue_count;

  modport master (
    output req_valid, req_addr, req_op, req_lvl,
    input  req_ready, cache_addr, cache_op, cache_lvl, grant_id, busy, bad_op, issue_count
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_lvl,
    output req_ready, cache_addr, cache_op, cache_lvl, grant_id, busy, bad_op, issue_count
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first valid requester at or above ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter  int N     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [N-1:0]     hi_mask;
  logic [N-1:0]     req_hi;
  logic [N-1:0]     grant_hi;
  logic [N-1:0]     grant_lo;
  logic [IDX_W-1:0] idx_chain [N+1];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign hi_mask[gi] = (IDX_W'(gi) >= ptr_i);
    end
  endgenerate

  // Lowest set bit of the upper half wins; otherwise wrap to the lowest set bit overall.
  assign req_hi   = valid_i & hi_mask;
  assign grant_hi = req_hi & (~req_hi + N'(1));
  assign grant_lo = valid_i & (~valid_i + N'(1));
  assign grant_o  = (|req_hi) ? grant_hi : grant_lo;
  assign any_o    = |valid_i;

  assign idx_chain[0] = '0;
  generate
    for (gi = 0; gi < N; gi++) begin : g_enc
      assign idx_chain[gi+1] = idx_chain[gi] | (grant_o[gi] ? IDX_W'(gi) : '0);
    end
  endgenerate
  assign idx_o = idx_chain[N];

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares the cache_top access port between requesters: round-robin accept, hold each access
// for HOLD_CYCLES clocks, drop illegal opcodes and count issued accesses.
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  cache_req_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  arb_state_t        state_q;
  logic [HC_W-1:0]   hold_cnt_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [IDX_W-1:0]  rr_ptr_d;
  logic [IDX_W-1:0]  grant_id_q;
  logic [ADDR_W-1:0] cache_addr_q;
  logic [7:0]        cache_op_q;
  logic              cache_lvl_q;
  logic              busy_q;
  logic              bad_op_q;
  logic [CNT_W-1:0]  issue_cnt_q;
  logic [CNT_W-1:0]  issue_cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               accept_win;
  logic               hs;
  logic               sel_legal;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [7:0]        op_arr   [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
      assign op_arr[gi]   = bus.req_op[gi*8 +: 8];
    end
  endgenerate

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // The window reopens on the last held cycle so back-to-back accesses have no idle gap.
  assign accept_win    = !reset && ((state_q == IDLE) || (hold_cnt_q == '0));
  assign hs            = accept_win && arb_any;
  assign bus.req_ready = accept_win ? arb_grant : '0;
  assign sel_legal     = is_legal_op(op_arr[arb_idx]);
  assign rr_ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
  assign issue_cnt_d   = issue_cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      cache_addr_q <= '0;
      cache_op_q   <= OP_IDLE;
      cache_lvl_q  <= 1'b0;
      busy_q       <= 1'b0;
      bad_op_q     <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      bad_op_q <= 1'b0;
      if (hs) begin
        rr_ptr_q <= rr_ptr_d;
        if (sel_legal) begin
          state_q      <= HOLD;
          hold_cnt_q   <= HOLD_LAST;
          grant_id_q   <= arb_idx;
          cache_addr_q <= addr_arr[arb_idx];
          cache_op_q   <= op_arr[arb_idx];
          cache_lvl_q  <= bus.req_lvl[arb_idx];
          busy_q       <= 1'b1;
          issue_cnt_q  <= issue_cnt_d;
        end else begin
          // Request is consumed but nothing is issued; any held access ends here.
          state_q    <= IDLE;
          hold_cnt_q <= '0;
          cache_op_q <= OP_IDLE;
          busy_q     <= 1'b0;
          bad_op_q   <= 1'b1;
        end
      end else if (state_q == HOLD) begin
        if (hold_cnt_q == '0) begin
          state_q    <= IDLE;
          cache_op_q <= OP_IDLE;
          busy_q     <= 1'b0;
        end else begin
          hold_cnt_q <= hold_cnt_q - HC_W'(1);
        end
      end
    end
  end

  assign bus.cache_addr  = cache_addr_q;
  assign bus.cache_op    = cache_op_q;
  assign bus.cache_lvl   = cache_lvl_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = busy_q;
  assign bus.bad_op      = bad_op_q;
  assign bus.issue_count = issue_cnt_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed and random checks of two arbiter instances (hold 5 and hold 1) against an
// access-visibility model that tracks how many more cycles the current access stays on the port.
module tb_cache_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 48;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_req_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .CNT_W(CW)) if5 ();
  cache_req_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .CNT_W(CW)) if1 ();

  cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .HOLD_CYCLES(5), .CNT_W(CW)) dut5 (
    .clk(clk), .reset(rst), .bus(if5.slave));
  cache_req_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .HOLD_CYCLES(1), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(rst), .bus(if1.slave));

  // Per-DUT stimulus (index 0 = hold 5, index 1 = hold 1)
  logic [N-1:0]  vld  [2];
  logic [AW-1:0] a_in [2][N];
  logic [7:0]    o_in [2][N];
  logic [N-1:0]  l_in [2];
  int            md   [2][N];   // 0 one-shot, 1 stay valid, 2 random, 3 legal stream

  logic [N-1:0]  rdy  [2];
  logic [AW-1:0] caddr[2];
  logic [7:0]    cop  [2];
  logic          clvl [2];
  logic          gid  [2];
  logic          bsy  [2];
  logic          bad  [2];
  logic [CW-1:0] cnt  [2];

  assign if5.req_valid = vld[0];
  assign if1.req_valid = vld[1];
  assign if5.req_lvl   = l_in[0];
  assign if1.req_lvl   = l_in[1];
  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign if5.req_addr[gi*AW +: AW] = a_in[0][gi];
    assign if1.req_addr[gi*AW +: AW] = a_in[1][gi];
    assign if5.req_op[gi*8 +: 8]     = o_in[0][gi];
    assign if1.req_op[gi*8 +: 8]     = o_in[1][gi];
  end
  assign rdy[0] = if5.req_ready;    assign rdy[1] = if1.req_ready;
  assign caddr[0] = if5.cache_addr; assign caddr[1] = if1.cache_addr;
  assign cop[0] = if5.cache_op;     assign cop[1] = if1.cache_op;
  assign clvl[0] = if5.cache_lvl;   assign clvl[1] = if1.cache_lvl;
  assign gid[0] = if5.grant_id;     assign gid[1] = if1.grant_id;
  assign bsy[0] = if5.busy;         assign bsy[1] = if1.busy;
  assign bad[0] = if5.bad_op;       assign bad[1] = if1.bad_op;
  assign cnt[0] = if5.issue_count;  assign cnt[1] = if1.issue_count;

  // Reference model state
  int            hold_len [2] = '{5, 1};
  int            m_rr  [2];
  int            m_left[2];     // cycles the current access is still visible, 0 = idle
  int            m_cnt [2];
  int            m_gid [2];
  logic [7:0]    m_op  [2];
  logic [AW-1:0] m_addr[2];
  logic          m_lvl [2];
  logic          m_bad [2];

  int n_assert = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  task automatic chk(input string tag, input int d, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d @%0t: observed %0h expected %0h", tag, d, $time, obs, exp);
    end
  endtask

  function automatic int pick(input int d);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr[d] + k) % N;
      if (vld[d][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_update(input int d, input int g);
    if (rst) begin
      m_rr[d] = 0; m_left[d] = 0; m_cnt[d] = 0; m_gid[d] = 0;
      m_op[d] = 8'h00; m_addr[d] = '0; m_lvl[d] = 1'b0; m_bad[d] = 1'b0;
    end else begin
      m_bad[d] = 1'b0;
      if (g >= 0) begin
        m_rr[d] = (g + 1) % N;
        if (o_in[d][g] == 8'h52 || o_in[d][g] == 8'h57) begin
          m_op[d]   = o_in[d][g];
          m_addr[d] = a_in[d][g];
          m_lvl[d]  = l_in[d][g];
          m_gid[d]  = g;
          m_left[d] = hold_len[d];
          m_cnt[d]  = (m_cnt[d] + 1) % (1 << CW);
        end else begin
          m_bad[d]  = 1'b1;
          m_left[d] = 0;
          m_op[d]   = 8'h00;
        end
      end else if (m_left[d] > 0) begin
        m_left[d]--;
        if (m_left[d] == 0) m_op[d] = 8'h00;
      end
    end
  endtask

  task automatic new_req(input int d, input int i, input bit legal_only);
    a_in[d][i] = AW'({$urandom(), $urandom()});
    if (!legal_only && $urandom_range(0, 7) == 0) o_in[d][i] = 8'h41 + 8'($urandom_range(0, 3));
    else o_in[d][i] = ($urandom_range(0, 1) == 1) ? 8'h52 : 8'h57;
    l_in[d][i] = 1'($urandom_range(0, 1));
    vld[d][i]  = 1'b1;
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic step();
    int g [2];
    logic [N-1:0] hs [2];
    logic [N-1:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      g[d] = (rst || m_left[d] > 1) ? -1 : pick(d);
      er = '0;
      if (g[d] >= 0) er[g[d]] = 1'b1;
      chk("req_ready", d, 64'(rdy[d]), 64'(er));
      hs[d] = vld[d] & rdy[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_update(d, g[d]);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("cache_op",    d, 64'(cop[d]),   64'(m_op[d]));
      chk("cache_addr",  d, 64'(caddr[d]), 64'(m_addr[d]));
      chk("cache_lvl",   d, 64'(clvl[d]),  64'(m_lvl[d]));
      chk("grant_id",    d, 64'(gid[d]),   64'(m_gid[d]));
      chk("busy",        d, 64'(bsy[d]),   64'(m_left[d] > 0));
      chk("bad_op",      d, 64'(bad[d]),   64'(m_bad[d]));
      chk("issue_count", d, 64'(cnt[d]),   64'(m_cnt[d]));
    end
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[d][i]) begin
          if (verbose)
            $display("[%0t] dut%0d req%0d accepted op=%02h addr=%012h lvl=%0d",
                     $time, d, i, o_in[d][i], a_in[d][i], l_in[d][i]);
          case (md[d][i])
            0: vld[d][i] = 1'b0;
            2: vld[d][i] = 1'b0;
            3: new_req(d, i, 1'b1);
            default: ;
          endcase
        end
        if (md[d][i] == 2 && !vld[d][i] && $urandom_range(0, 2) == 0) new_req(d, i, 1'b0);
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0;
      for (int i = 0; i < N; i++) md[d][i] = 0;
    end
    steps(2);
    chk("rst_cache_op", 0, 64'(cop[0]), 64'h00);
    chk("rst_busy",     0, 64'(bsy[0]), 64'h0);
    chk("rst_count",    1, 64'(cnt[1]), 64'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = '0; l_in[d] = '0;
      for (int i = 0; i < N; i++) begin
        a_in[d][i] = '0; o_in[d][i] = 8'h00; md[d][i] = 0;
      end
      m_rr[d] = 0; m_left[d] = 0; m_cnt[d] = 0; m_gid[d] = 0;
      m_op[d] = 8'h00; m_addr[d] = '0; m_lvl[d] = 1'b0; m_bad[d] = 1'b0;
    end

    // Single request from req0
    do_reset();
    a_in[0][0] = 48'h7fff493822b8; o_in[0][0] = 8'h57; l_in[0][0] = 1'b0; vld[0][0] = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      chk("single_op",   0, 64'(cop[0]),   64'h57);
      chk("single_addr", 0, 64'(caddr[0]), 64'h7fff493822b8);
      step();
    end
    chk("single_idle",  0, 64'(cop[0]), 64'h00);
    chk("single_count", 0, 64'(cnt[0]), 64'd1);

    // Contention: both requesters continuously valid
    do_reset();
    md[0][0] = 1; md[0][1] = 1;
    a_in[0][0] = 48'h0000_1000_0040; o_in[0][0] = 8'h52; l_in[0][0] = 1'b0;
    a_in[0][1] = 48'h0000_2000_0080; o_in[0][1] = 8'h57; l_in[0][1] = 1'b1;
    vld[0] = 2'b11;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("cont_busy", 0, 64'(bsy[0]), 64'h1);
      if (k % 5 == 0) begin
        chk("cont_gid", 0, 64'(gid[0]), 64'((k / 5) % 2));
        chk("cont_op",  0, 64'(cop[0]), ((k / 5) % 2 == 0) ? 64'h52 : 64'h57);
      end
    end
    chk("cont_count", 0, 64'(cnt[0]), 64'd4);
    vld[0] = '0; md[0][0] = 0; md[0][1] = 0;
    steps(6);

    // Illegal opcode from req1 after a legal req0 access (pointer sits at 1)
    do_reset();
    a_in[0][0] = 48'h0000_0000_1234; o_in[0][0] = 8'h52; vld[0][0] = 1'b1;
    steps(6);
    a_in[0][1] = 48'h0000_0000_5678; o_in[0][1] = 8'h41; vld[0][1] = 1'b1;
    step();
    chk("illegal_bad",   0, 64'(bad[0]), 64'h1);
    chk("illegal_op",    0, 64'(cop[0]), 64'h00);
    chk("illegal_count", 0, 64'(cnt[0]), 64'd1);
    step();
    chk("illegal_pulse", 0, 64'(bad[0]), 64'h0);
    md[0][0] = 1; md[0][1] = 1; o_in[0][1] = 8'h57; vld[0] = 2'b11;
    step();
    chk("illegal_next_gid", 0, 64'(gid[0]), 64'd0);
    vld[0] = '0; md[0][0] = 0; md[0][1] = 0;
    steps(6);

    // Reset on the third hold cycle with req1 waiting
    do_reset();
    a_in[0][0] = 48'h0000_00ab_cdef; o_in[0][0] = 8'h57; vld[0][0] = 1'b1;
    steps(3);
    rst = 1'b1;
    a_in[0][1] = 48'h0000_0fed_cba9; o_in[0][1] = 8'h52; l_in[0][1] = 1'b1; vld[0][1] = 1'b1;
    step();
    chk("midrst_op",    0, 64'(cop[0]), 64'h00);
    chk("midrst_busy",  0, 64'(bsy[0]), 64'h0);
    chk("midrst_count", 0, 64'(cnt[0]), 64'd0);
    rst = 1'b0;
    step();
    chk("midrst_gid", 0, 64'(gid[0]), 64'd1);
    chk("midrst_op2", 0, 64'(cop[0]), 64'h52);
    steps(6);

    // Hold-1 instance streaming 100 R/W accesses from req0
    do_reset();
    md[1][0] = 3; new_req(1, 0, 1'b1);
    steps(100);
    chk("stream_count", 1, 64'(cnt[1]), 64'd100);

    // Counter wrap on the hold-1 instance while the hold-5 instance sees random traffic
    do_reset();
    verbose = 1'b0;
    md[1][0] = 3; new_req(1, 0, 1'b1);
    md[0][0] = 2; md[0][1] = 2;
    steps(4096);
    chk("wrap_count", 1, 64'(cnt[1]), 64'd0);
    chk("wrap_busy",  1, 64'(bsy[1]), 64'h1);
    chk("wrap_bad",   1, 64'(bad[1]), 64'h0);

    // Random traffic on both instances
    md[1][0] = 2; md[1][1] = 2;
    steps(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
